// File: rtl/divider8x4_seq.sv
// Iterative restoring divider: 8-bit unsigned dividend / 4-bit unsigned divisor,
// one quotient bit per clock, fixed 10-cycle throughput with start/ready/done handshake.
module divider8x4_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] state;
   logic [7:0] dreg;
   logic [3:0] vreg;
   logic [4:0] rreg;
   logic [2:0] count;
   logic [3:0] dvd_lo;
   logic       zero_div;

   logic [4:0] trial;
   logic       qbit;
   logic [4:0] r_next;
   logic [7:0] d_next;

   // One restoring step: trial subtract of the divisor from the shifted partial remainder
   always_comb begin
      trial = {rreg[3:0], dreg[7]};
      if (trial >= {1'b0, vreg}) begin
         qbit   = 1'b1;
         r_next = trial - {1'b0, vreg};
      end else begin
         qbit   = 1'b0;
         r_next = trial;
      end
      d_next = {dreg[6:0], qbit};
   end

   // Handshake flags are pure state decodes, so exactly one is high per cycle
   always_comb begin
      ready = (state == S_IDLE);
      busy  = (state == S_RUN);
      done  = (state == S_DONE);
   end

   // Control FSM, iteration datapath and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         dreg        <= 8'h00;
         vreg        <= 4'h0;
         rreg        <= 5'h00;
         count       <= 3'd0;
         dvd_lo      <= 4'h0;
         zero_div    <= 1'b0;
         quotient    <= 8'h00;
         remainder   <= 4'h0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dreg     <= dividend;
                  vreg     <= divisor;
                  rreg     <= 5'h00;
                  count    <= 3'd7;
                  dvd_lo   <= dividend[3:0];
                  zero_div <= (divisor == 4'h0);
                  state    <= S_RUN;
               end else begin
                  state    <= S_IDLE;
               end
            end
            S_RUN: begin
               dreg <= d_next;
               rreg <= r_next;
               // Results are loaded on the last step so they are valid while done is high
               if (count == 3'd0) begin
                  state       <= S_DONE;
                  div_by_zero <= zero_div;
                  if (zero_div) begin
                     quotient  <= 8'hFF;
                     remainder <= dvd_lo;
                  end else begin
                     quotient  <= d_next;
                     remainder <= r_next[3:0];
                  end
               end else begin
                  count <= count - 3'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider8x4_seq.sv
// Self-checking bench for divider8x4_seq: directed table, handshake corner cases,
// randomized operands against an arithmetic model, and a back-to-back exhaustive sweep.
module tb_divider8x4_seq;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;
   int onehot_viol = 0;

   divider8x4_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((int'(ready) + int'(busy) + int'(done)) != 1) onehot_viol++;
   end

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Arithmetic reference: plain division, with the divide-by-zero convention
   task automatic model(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r, output logic z);
      if (b == 4'd0) begin
         q = 8'hFF;
         r = a[3:0];
         z = 1'b1;
      end else begin
         q = 8'(a / b);
         r = 4'(a % b);
         z = 1'b0;
      end
   endtask

   // Called on a falling edge; returns on the falling edge where done is seen
   task automatic do_op(input logic [7:0] a, input logic [3:0] b, input bit hold, output int lat);
      int guard;
      guard = 0;
      while (!ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         lat++;
      end while (!done && lat < 20);
      if (!done) check("done_timeout", lat, 9);
   endtask

   initial begin
      vec_t       vecs[7];
      int         lat;
      int         done_cnt;
      int         ready_at10;
      logic [7:0] eq;
      logic [3:0] er;
      logic       ez;

      vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
      vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
      vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
      vecs[3] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
      vecs[4] = '{8'd0,   4'd3,  8'd0,   4'd0,  1'b0};
      vecs[5] = '{8'hAD,  4'd0,  8'hFF,  4'hD,  1'b1};
      vecs[6] = '{8'd14,  4'd3,  8'd4,   4'd2,  1'b0};

      reset = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", int'(ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_dbz", int'(div_by_zero), 0);

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, 1'b0, lat);
         check("tbl_latency", lat, 9);
         check("tbl_quotient", int'(quotient), int'(vecs[i].q));
         check("tbl_remainder", int'(remainder), int'(vecs[i].r));
         check("tbl_dbz", int'(div_by_zero), int'(vecs[i].z));
         @(negedge clk);
         check("tbl_ready_after", int'(ready), 1);
      end

      // start pulsed mid-run must be ignored
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      @(posedge clk);
      done_cnt = 0; ready_at10 = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (c == 3) begin
            start = 1'b1; dividend = 8'd99; divisor = 4'd4;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_cnt++;
            check("busy_start_q", int'(quotient), 28);
            check("busy_start_r", int'(remainder), 4);
            check("busy_start_done_cycle", c, 9);
         end
         if (c == 10) ready_at10 = int'(ready);
      end
      check("busy_start_done_count", done_cnt, 1);
      check("busy_start_ready_c10", ready_at10, 1);

      // Asynchronous reset mid-run
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 reset = 1'b1;
      #1;
      check("midrst_ready", int'(ready), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_quotient", int'(quotient), 0);
      check("midrst_remainder", int'(remainder), 0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      do_op(8'd60, 4'd6, 1'b0, lat);
      check("post_rst_q", int'(quotient), 10);
      check("post_rst_r", int'(remainder), 0);
      @(negedge clk);

      // Randomized operands against the model
      for (int k = 0; k < 300; k++) begin
         logic [7:0] a;
         logic [3:0] b;
         a = 8'($urandom_range(0, 255));
         b = 4'($urandom_range(0, 15));
         model(a, b, eq, er, ez);
         do_op(a, b, 1'b0, lat);
         check("rnd_latency", lat, 9);
         check("rnd_quotient", int'(quotient), int'(eq));
         check("rnd_remainder", int'(remainder), int'(er));
         check("rnd_dbz", int'(div_by_zero), int'(ez));
         @(negedge clk);
      end

      // Exhaustive sweep, start held high: each op must be accepted on the cycle ready returns
      onehot_viol = 0;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            check("sweep_ready", int'(ready), 1);
            do_op(8'(a), 4'(b), 1'b1, lat);
            check("sweep_latency", lat, 9);
            if (b != 0) begin
               check("sweep_identity", int'(quotient) * b + int'(remainder), a);
               check("sweep_rem_lt_div", int'(int'(remainder) < b), 1);
               check("sweep_dbz_clear", int'(div_by_zero), 0);
            end else begin
               check("sweep_dbz_q", int'(quotient), 255);
               check("sweep_dbz_r", int'(remainder), a % 16);
               check("sweep_dbz_flag", int'(div_by_zero), 1);
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      check("onehot_violations", onehot_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
